// File: rtl/div_pkg.sv
// Shared types and helpers for the divider issue front-end.
package div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } div_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } div_state_e;

   localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;

   function automatic logic [63:0] sext32(input logic [63:0] v);
      return {{32{v[31]}}, v[31:0]};
   endfunction

endpackage

// File: rtl/div_special_chk.sv
// Detects divide-by-zero and signed overflow on the effective operands and
// produces the architectural result for those cases without running the divider.
module div_special_chk
   import div_pkg::*;
(
   input  div_op_e     op,
   input  logic        word,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   output logic        is_special,
   output logic [63:0] result
);

   logic        op_signed;
   logic        op_rem;
   logic        div_zero;
   logic        overflow;
   logic [63:0] dividend_eff;
   logic [63:0] raw;

   assign op_signed = (op == OP_DIV) || (op == OP_REM);
   assign op_rem    = (op == OP_REM) || (op == OP_REMU);

   // W forms only look at the low halves; unsigned W dividend is zero-extended.
   assign dividend_eff = (word && !op_signed) ? {32'd0, src1[31:0]} : src1;

   assign div_zero = word ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
   assign overflow = op_signed &&
                     (word ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                           : ((src1 == XLEN_MIN) && (src2 == 64'hFFFF_FFFF_FFFF_FFFF)));

   assign is_special = div_zero || overflow;

   always_comb begin
      raw = '0;
      if (div_zero) begin
         raw = op_rem ? dividend_eff : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (overflow) begin
         raw = op_rem ? 64'd0 : dividend_eff;
      end
   end

   assign result = word ? sext32(raw) : raw;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/response controller for the iterative 64-bit divider.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             div_valid,
   output logic             div_sign,
   output logic             div_word,
   output logic [XLEN-1:0]  div_dividend,
   output logic [XLEN-1:0]  div_divisor,
   input  logic [XLEN-1:0]  div_quotient,
   input  logic [XLEN-1:0]  div_remainder,
   input  logic             div_done
);

   div_state_e       state_reg, state_next;
   logic [XLEN-1:0]  out_result_reg, out_result_next;
   logic [TAG_W-1:0] out_tag_reg;
   logic             div_sign_reg, div_word_reg, word_reg, rem_reg;
   logic [XLEN-1:0]  dividend_reg, divisor_reg;
   logic             launch_load;

   logic             accept;
   logic             in_signed;
   logic [XLEN-1:0]  src1_prep, src2_prep;
   logic             spec_hit;
   logic [XLEN-1:0]  spec_result;
   logic             cache_hit;
   logic [XLEN-1:0]  cache_result;
   logic [XLEN-1:0]  done_raw;

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_RESP);
   assign div_valid = (state_reg == ST_LAUNCH);
   assign accept    = in_valid && in_ready && !flush;
   assign in_signed = !in_op[0];

   // Signed W operands go through untouched; the divider sign-extends them in W mode.
   assign src1_prep = (in_word && !in_signed) ? {32'd0, in_src1[31:0]} : in_src1;
   assign src2_prep = (in_word && !in_signed) ? {32'd0, in_src2[31:0]} : in_src2;

   div_special_chk u_special (
      .op         (div_op_e'(in_op)),
      .word       (in_word),
      .src1       (in_src1),
      .src2       (in_src2),
      .is_special (spec_hit),
      .result     (spec_result)
   );

`ifdef DIV_RESULT_CACHE_EN
   logic            cache_valid_reg;
   logic [XLEN-1:0] cache_src1_reg, cache_src2_reg, cache_q_reg, cache_r_reg;
   logic            cache_word_reg, cache_sign_reg;
   logic [XLEN-1:0] cache_raw;

   // Refilled on every completion, even a drained one, so a flushed op still warms it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid_reg <= 1'b0;
         cache_src1_reg  <= '0;
         cache_src2_reg  <= '0;
         cache_q_reg     <= '0;
         cache_r_reg     <= '0;
         cache_word_reg  <= 1'b0;
         cache_sign_reg  <= 1'b0;
      end else if (div_done) begin
         cache_valid_reg <= 1'b1;
         cache_src1_reg  <= dividend_reg;
         cache_src2_reg  <= divisor_reg;
         cache_q_reg     <= div_quotient;
         cache_r_reg     <= div_remainder;
         cache_word_reg  <= word_reg;
         cache_sign_reg  <= div_sign_reg;
      end
   end

   assign cache_hit = cache_valid_reg && (cache_src1_reg == src1_prep) &&
                      (cache_src2_reg == src2_prep) && (cache_word_reg == in_word) &&
                      (cache_sign_reg == in_signed);
   assign cache_raw    = in_op[1] ? cache_r_reg : cache_q_reg;
   assign cache_result = in_word ? sext32(cache_raw) : cache_raw;
`else
   assign cache_hit    = 1'b0;
   assign cache_result = '0;
`endif

   assign done_raw = rem_reg ? div_remainder : div_quotient;

   always_comb begin
      state_next      = state_reg;
      out_result_next = out_result_reg;
      launch_load     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (spec_hit) begin
                  state_next      = ST_RESP;
                  out_result_next = spec_result;
               end else if (cache_hit) begin
                  state_next      = ST_RESP;
                  out_result_next = cache_result;
               end else begin
                  state_next  = ST_LAUNCH;
                  launch_load = 1'b1;
               end
            end
         end
         ST_LAUNCH: state_next = flush ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (div_done) begin
               state_next = flush ? ST_IDLE : ST_RESP;
               if (!flush) begin
                  out_result_next = word_reg ? sext32(done_raw) : done_raw;
               end
            end else if (flush) begin
               state_next = ST_DRAIN;
            end
         end
         ST_RESP: begin
            if (flush || out_ready) begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (div_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         out_result_reg <= '0;
         out_tag_reg    <= '0;
         div_sign_reg   <= 1'b0;
         div_word_reg   <= 1'b0;
         dividend_reg   <= '0;
         divisor_reg    <= '0;
         word_reg       <= 1'b0;
         rem_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         out_result_reg <= out_result_next;
         if (accept) begin
            out_tag_reg <= in_tag;
            rem_reg     <= in_op[1];
         end
         if (launch_load) begin
            dividend_reg <= src1_prep;
            divisor_reg  <= src2_prep;
            div_sign_reg <= in_signed;
            div_word_reg <= in_word && in_signed;
            word_reg     <= in_word;
         end
      end
   end

   assign out_result   = out_result_reg;
   assign out_tag      = out_tag_reg;
   assign div_sign     = div_sign_reg;
   assign div_word     = div_word_reg;
   assign div_dividend = dividend_reg;
   assign div_divisor  = divisor_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed testbench for div_issue_ctrl with a fixed-latency divider stand-in.
module tb_div_issue_ctrl;

   localparam int LAT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_word, flush, out_valid, out_ready;
   logic [1:0]  in_op;
   logic [63:0] in_src1, in_src2, out_result;
   logic [4:0]  in_tag, out_tag;
   logic        div_valid, div_sign, div_word, div_done;
   logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

   int checks = 0;
   int failures = 0;
   int launch_cnt = 0;

   // divider model state
   logic        busy;
   int          cnt;
   logic [63:0] pend_q, pend_r, m_dividend, m_divisor;
   logic        m_sign, m_word;

   always #5 clk = ~clk;

   div_issue_ctrl #(.XLEN(64), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
      .div_valid(div_valid), .div_sign(div_sign), .div_word(div_word),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
   );

   function automatic logic [63:0] mdl(input logic [63:0] a, input logic [63:0] b,
                                       input logic sgn, input logic wrd, input logic rem);
      logic [63:0] ea, eb;
      ea = (sgn && wrd) ? {{32{a[31]}}, a[31:0]} : a;
      eb = (sgn && wrd) ? {{32{b[31]}}, b[31:0]} : b;
      if (eb == 64'd0) return rem ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
      if (sgn) return rem ? 64'($signed(ea) % $signed(eb)) : 64'($signed(ea) / $signed(eb));
      return rem ? ea % eb : ea / eb;
   endfunction

   always @(posedge clk) begin
      div_done <= 1'b0;
      if (div_valid) launch_cnt <= launch_cnt + 1;
      if (rst) begin
         busy          <= 1'b0;
         cnt           <= 0;
         div_quotient  <= '0;
         div_remainder <= '0;
      end else if (div_valid) begin
         busy       <= 1'b1;
         cnt        <= LAT;
         pend_q     <= mdl(div_dividend, div_divisor, div_sign, div_word, 1'b0);
         pend_r     <= mdl(div_dividend, div_divisor, div_sign, div_word, 1'b1);
         m_dividend <= div_dividend;
         m_divisor  <= div_divisor;
         m_sign     <= div_sign;
         m_word     <= div_word;
      end else if (busy) begin
         if (cnt == 1) begin
            busy          <= 1'b0;
            div_done      <= 1'b1;
            div_quotient  <= pend_q;
            div_remainder <= pend_r;
         end
         cnt <= cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("issue_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_tag = t;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get_result(output logic [63:0] r, output logic [4:0] t, output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("resp_timeout", 64'(lat < 200), 64'd1);
      r = out_result;
      t = out_tag;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] r;
      logic [4:0]  t;
      int          lat, l0, n;
      logic        seen;

      rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0; in_src1 = '0; in_src2 = '0;
      in_tag = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_div_valid", 64'(div_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_div_ops", {62'd0, div_sign, div_word} | div_dividend | div_divisor, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: DIV / REM 100, -7
      l0 = launch_cnt;
      issue(2'd0, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd3);
      chk("t1_div_valid", 64'(div_valid), 64'd1);
      get_result(r, t, lat);
      chk("t1_div_result", r, 64'hFFFF_FFFF_FFFF_FFF2);
      chk("t1_div_tag", 64'(t), 64'd3);
      chk("t1_launches", 64'(launch_cnt - l0), 64'd1);
      chk("t1_dividend", m_dividend, 64'd100);
      chk("t1_divisor", m_divisor, 64'hFFFF_FFFF_FFFF_FFF9);
      chk("t1_sign_word", {62'd0, m_sign, m_word}, 64'd2);
      issue(2'd2, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd4);
      get_result(r, t, lat);
      chk("t1_rem_result", r, 64'd2);
      chk("t1_rem_tag", 64'(t), 64'd4);

      // 2: divide by zero bypass
      l0 = launch_cnt;
      issue(2'd1, 1'b0, 64'd1234, 64'd0, 5'd5);
      get_result(r, t, lat);
      chk("t2_divu0_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t2_divu0_lat", 64'(lat), 64'd0);
      issue(2'd3, 1'b0, 64'd5, 64'd0, 5'd6);
      get_result(r, t, lat);
      chk("t2_remu0_result", r, 64'd5);
      chk("t2_remu0_tag", 64'(t), 64'd6);
      chk("t2_no_launch", 64'(launch_cnt - l0), 64'd0);

      // 3: W forms
      l0 = launch_cnt;
      issue(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
      get_result(r, t, lat);
      chk("t3_divw_ovf", r, 64'hFFFF_FFFF_8000_0000);
      chk("t3_divw_lat", 64'(lat), 64'd0);
      chk("t3_no_launch", 64'(launch_cnt - l0), 64'd0);
      issue(2'd1, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'h1234_0000_0000_0001, 5'd8);
      get_result(r, t, lat);
      chk("t3_divuw_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_divuw_dividend", m_dividend, 64'h0000_0000_FFFF_FFFF);
      chk("t3_divuw_word", 64'(m_word), 64'd0);
      issue(2'd2, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd3, 5'd9);
      get_result(r, t, lat);
      chk("t3_remw_result", r, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_remw_word", 64'(m_word), 64'd1);

      // flush beats in_valid in IDLE
      l0 = launch_cnt;
      in_valid = 1'b1; flush = 1'b1; in_op = 2'd0; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd3;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_idle_ready", 64'(in_ready), 64'd1);
      chk("fl_idle_nolaunch", 64'(div_valid) | 64'(launch_cnt - l0), 64'd0);

      // flush in RESP drops the result
      issue(2'd1, 1'b0, 64'd1, 64'd0, 5'd10);
      chk("fl_resp_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_resp_dropped", 64'(out_valid), 64'd0);

      // 4: flush 10 cycles after launch -> drain
      issue(2'd0, 1'b0, 64'd1000, 64'd10, 5'd11);
      chk("t4_launch", 64'(div_valid), 64'd1);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t4_drain_ready", 64'(in_ready), 64'd0);
      n = 0; seen = 1'b0;
      while (!in_ready && n < 50) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("t4_drain_exit", 64'(in_ready), 64'd1);
      chk("t4_drain_len", 64'(n >= 2), 64'd1);
      chk("t4_no_out_valid", 64'(seen | out_valid), 64'd0);
      issue(2'd1, 1'b0, 64'd50, 64'd7, 5'd12);
      get_result(r, t, lat);
      chk("t4_next_result", r, 64'd7);
      chk("t4_next_tag", 64'(t), 64'd12);

      // 5: backpressure in RESP
      issue(2'd0, 1'b0, 64'd81, 64'd9, 5'd13);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_result", out_result, 64'd9);
         chk("t5_hold_tag", 64'(out_tag), 64'd13);
         chk("t5_hold_busy", {62'd0, in_ready, out_valid}, 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t5_one_transfer", {62'd0, in_ready, out_valid}, 64'd2);

      // 6: DIV then REM with identical operands
      issue(2'd0, 1'b0, 64'd77, 64'd5, 5'd14);
      get_result(r, t, lat);
      chk("t6_div_result", r, 64'd15);
      l0 = launch_cnt;
      issue(2'd2, 1'b0, 64'd77, 64'd5, 5'd15);
      get_result(r, t, lat);
      chk("t6_rem_result", r, 64'd2);
      chk("t6_rem_tag", 64'(t), 64'd15);
`ifdef DIV_RESULT_CACHE_EN
      chk("t6_launches", 64'(launch_cnt - l0), 64'd0);
`else
      chk("t6_launches", 64'(launch_cnt - l0), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
